fib_scan_seq: RTL

FIB_SCAN_SEQ -- requirements
Module: fib_scan_seq

---
 rtl/fib_scan_seq.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/fib_scan_seq.sv
// fib_scan_seq
//   Fibonacci sequence generator with a multiplexed hex-digit scanner.
//   The sequence advances either automatically every TICK_DIV clocks
//   (step_mode=0) or once per rising edge of step (step_mode=1). When the
//   next sum no longer fits in WIDTH bits, the sequence either restarts at
//   0,1 with a one-cycle overflow pulse (WRAP=1), or freezes in HALT with a
//   sticky overflow flag (WRAP=0). A free-running scanner walks a one-hot
//   digit select across NUM_DIGITS nibbles of the current value.
//
// Ports
//   clk        in   single clock, rising edge
//   reset      in   synchronous active-high reset
//   enable     in   permits advances when high
//   step_mode  in   0 = free-run every TICK_DIV clocks, 1 = manual step
//   step       in   manual advance request (rising edge counts)
//   value      out  [WIDTH]      current sequence term
//   overflow   out               overflow indication
//   segment    out  [4]          nibble of value for the selected digit
//   digit      out  [NUM_DIGITS] one-hot active-high digit select
module fib_scan_seq #(
  parameter int WIDTH      = 16,
  parameter int NUM_DIGITS = 4,
  parameter int TICK_DIV   = 4,
  parameter int SCAN_DIV   = 2,
  parameter int WRAP       = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  step_mode,
  input  logic                  step,
  output logic [WIDTH-1:0]      value,
  output logic                  overflow,
  output logic [3:0]            segment,
  output logic [NUM_DIGITS-1:0] digit
);

  localparam int TW = (TICK_DIV > 1)   ? $clog2(TICK_DIV)   : 1;
  localparam int SW = (SCAN_DIV > 1)   ? $clog2(SCAN_DIV)   : 1;
  localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DIGIT_LAST = DW'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH:0]   w_sum;
  logic             w_carry;

  logic [TW-1:0]    r_tick;
  logic             r_step_q;
  logic             r_mode_q;
  logic             r_ovf;

  logic [SW-1:0]    r_scan_div;
  logic [DW-1:0]    r_sel;

  logic             w_step_rise;
  logic             w_tick_hit;
  logic             w_mode_chg;
  logic             w_adv;
  logic             w_ovf_adv;

  // Sum carried one bit wider so the carry out flags an overflow advance.
  assign w_sum       = {1'b0, r_a} + {1'b0, r_b};
  assign w_carry     = w_sum[WIDTH];
  assign w_step_rise = step & ~r_step_q;
  assign w_tick_hit  = (r_tick == TICK_LAST);

  // A step_mode flip seen while running restarts pacing from scratch, so
  // no advance is taken on that cycle in either mode.
  assign w_mode_chg  = (r_state == S_RUN) && (step_mode != r_mode_q);
  assign w_ovf_adv   = w_adv & w_carry;

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ---------------------------------------------------------------------
  // FSM: next state and advance decision
  // ---------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    w_adv        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (enable) begin
          w_state_next = S_RUN;
        end
      end
      S_RUN: begin
        if (!enable) begin
          w_state_next = S_IDLE;
        end else begin
          if (!w_mode_chg) begin
            w_adv = step_mode ? w_step_rise : w_tick_hit;
          end
          if (w_adv && w_carry && (WRAP == 0)) begin
            w_state_next = S_HALT;
          end
        end
      end
      S_HALT: begin
        // Only reset leaves HALT.
        w_state_next = S_HALT;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Sequence datapath, pacing and overflow flag
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_a      <= '0;
      r_b      <= WIDTH'(1);
      r_ovf    <= 1'b0;
      r_tick   <= '0;
      r_step_q <= 1'b0;
      r_mode_q <= step_mode;
    end else begin
      r_mode_q <= step_mode;
      r_step_q <= w_mode_chg ? 1'b0 : step;

      if (w_mode_chg) begin
        r_tick <= '0;
      end else if ((r_state == S_RUN) && enable && !step_mode) begin
        r_tick <= w_tick_hit ? '0 : r_tick + TW'(1);
      end

      if (w_adv) begin
        if (w_carry) begin
          // Without wrap the terms are frozen; FSM moves to HALT.
          if (WRAP != 0) begin
            r_a <= '0;
            r_b <= WIDTH'(1);
          end
        end else begin
          r_a <= r_b;
          r_b <= w_sum[WIDTH-1:0];
        end
      end

      if (WRAP != 0) begin
        r_ovf <= w_ovf_adv;
      end else if (w_ovf_adv) begin
        r_ovf <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Digit scanner: runs in every state
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_scan_div <= '0;
      r_sel      <= '0;
    end else if (r_scan_div == SCAN_LAST) begin
      r_scan_div <= '0;
      r_sel      <= (r_sel == DIGIT_LAST) ? '0 : r_sel + DW'(1);
    end else begin
      r_scan_div <= r_scan_div + SW'(1);
    end
  end

  // Nibble table; digits beyond the value width show 0.
  logic [3:0] w_nib [NUM_DIGITS];

  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      if (4 * gi < WIDTH) begin : g_in_range
        assign w_nib[gi] = r_a[4*gi +: 4];
      end else begin : g_out_range
        assign w_nib[gi] = 4'h0;
      end
      assign digit[gi] = (r_sel == DW'(gi));
    end
  endgenerate

  assign segment  = w_nib[r_sel];
  assign value    = r_a;
  assign overflow = r_ovf;

endmodule
